pilsner_referee: RTL and testbench

- Game-rule engine for the Pilsner game: watches the per-pixel `print` outputs of the player and of N falling bottles during the VGA scan, and decides catches and misses.
- Drives each bottle's `collision` input, so a caught bottle resets and respawns.
- Keeps score, lives and level, and owns the global `pause` signal that freezes all renderers and physics.
- Sits between the bottle/player object instances and the VGA/scoreboard logic, clocked at 50 MHz.

---
 rtl/pilsner_referee.sv | 128 ++++++++++++
 tb/tb_pilsner_referee.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/pilsner_referee.sv
// rtl/pilsner_referee.sv - Pilsner game referee: catch/miss detection, score, lives, level, pause
module pilsner_referee #(
    parameter int N_BOTTLES  = 4,
    parameter int LIVES_INIT = 3,
    parameter int MISS_Y     = 460,
    parameter int LEVEL_STEP = 10,
    parameter int MAX_LEVEL  = 7,
    parameter int X_DISPLAY  = 640,
    parameter int Y_DISPLAY  = 480
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [9:0]              x,
    input  logic [9:0]              y,
    input  logic                    player_print,
    input  logic [N_BOTTLES-1:0]    bottle_print,
    input  logic [10*N_BOTTLES-1:0] bottle_py,
    input  logic                    start,
    input  logic                    pause_btn,
    output logic [N_BOTTLES-1:0]    collision,
    output logic                    pause,
    output logic [15:0]             score,
    output logic [3:0]              lives,
    output logic [2:0]              level,
    output logic                    game_over
);
    typedef enum logic [1:0] {IDLE, PLAY, PAUSED, OVER} state_t;

    localparam logic [9:0] MISS_Y_L    = 10'(MISS_Y);
    localparam logic [9:0] X_DISP_L    = 10'(X_DISPLAY);
    localparam logic [9:0] Y_DISP_L    = 10'(Y_DISPLAY);
    localparam logic [3:0] LIVES_L     = 4'(LIVES_INIT);
    localparam logic [7:0] LEVEL_STEP_L = 8'(LEVEL_STEP);
    localparam logic [2:0] MAX_LEVEL_L = 3'(MAX_LEVEL);

    state_t                 state, state_nxt;
    logic [N_BOTTLES-1:0]   hit_pend, armed;
    logic [N_BOTTLES-1:0]   col_set, miss, above, overlap;
    logic [7:0]             catch_cnt, n_catch, n_miss, cnt_sum;
    logic [16:0]            score_sum;
    logic                   prev_zero, frame_tick, pb_prev, pb_rise, at_zero, on_screen;

    assign pause     = (state != PLAY);
    assign game_over = (state == OVER);

    always_comb begin
        at_zero   = (x == 10'd0) && (y == 10'd0);
        on_screen = (x < X_DISP_L) && (y < Y_DISP_L);
        pb_rise   = pause_btn & ~pb_prev;
        col_set   = '0;
        miss      = '0;
        above     = '0;
        overlap   = '0;
        n_catch   = 8'd0;
        n_miss    = 8'd0;
        for (int i = 0; i < N_BOTTLES; i++) begin
            above[i]   = bottle_py[10*i +: 10] < MISS_Y_L;
            // A bottle already flagged is in its reset cycle when it prints; not a new catch.
            overlap[i] = player_print & bottle_print[i] & on_screen & ~collision[i];
            if (state == PLAY) begin
                col_set[i] = frame_tick & hit_pend[i];
                miss[i]    = armed[i] & ~above[i] & ~collision[i] & ~hit_pend[i];
            end
            n_catch = n_catch + 8'(col_set[i]);
            n_miss  = n_miss + 8'(miss[i]);
        end
        score_sum = {1'b0, score} + {9'd0, n_catch};
        cnt_sum   = catch_cnt + n_catch;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = PLAY;
            PLAY: begin
                if (lives == 4'd0)  state_nxt = OVER;
                else if (pb_rise)   state_nxt = PAUSED;
            end
            PAUSED:  if (pb_rise) state_nxt = PLAY;
            OVER:    if (start) state_nxt = PLAY;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            collision  <= '0;
            score      <= 16'd0;
            lives      <= LIVES_L;
            level      <= 3'd0;
            catch_cnt  <= 8'd0;
            hit_pend   <= '0;
            armed      <= '0;
            prev_zero  <= 1'b0;
            frame_tick <= 1'b0;
            pb_prev    <= 1'b0;
        end else begin
            state      <= state_nxt;
            prev_zero  <= at_zero;
            frame_tick <= at_zero & ~prev_zero;
            pb_prev    <= pause_btn;
            if (state == PLAY) begin
                hit_pend  <= (state_nxt == PLAY) ? ((hit_pend & ~{N_BOTTLES{frame_tick}}) | overlap) : '0;
                collision <= (collision & ~bottle_print) | col_set;
                // A caught bottle disarms so its respawn must pass above MISS_Y again.
                armed     <= (armed & ~miss & ~col_set) | above;
                score     <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
                lives     <= (n_miss >= {4'd0, lives}) ? 4'd0 : lives - n_miss[3:0];
                if (cnt_sum >= LEVEL_STEP_L) begin
                    catch_cnt <= cnt_sum - LEVEL_STEP_L;
                    if (level < MAX_LEVEL_L) level <= level + 3'd1;
                end else begin
                    catch_cnt <= cnt_sum;
                end
            end else begin
                hit_pend <= '0;
                if ((state == IDLE || state == OVER) && start) begin
                    score     <= 16'd0;
                    lives     <= LIVES_L;
                    level     <= 3'd0;
                    catch_cnt <= 8'd0;
                    armed     <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_pilsner_referee.sv
// tb/tb_pilsner_referee.sv - directed self-checking bench for pilsner_referee
module tb_pilsner_referee;
    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  x, y;
    logic        player_print;
    logic [3:0]  bottle_print;
    logic [39:0] bottle_py;
    logic        start, pause_btn;
    logic [3:0]  collision;
    logic        pause;
    logic [15:0] score;
    logic [3:0]  lives;
    logic [2:0]  level;
    logic        game_over;

    int errors = 0;
    int checks = 0;
    int exp_score = 0;

    pilsner_referee dut (
        .clk(clk), .reset(reset), .x(x), .y(y),
        .player_print(player_print), .bottle_print(bottle_print),
        .bottle_py(bottle_py), .start(start), .pause_btn(pause_btn),
        .collision(collision), .pause(pause), .score(score), .lives(lives),
        .level(level), .game_over(game_over)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input int px, input int py, input logic pp, input logic [3:0] bp);
        x = 10'(px);
        y = 10'(py);
        player_print = pp;
        bottle_print = bp;
        tick();
    endtask

    task automatic set_py(input int i, input int v);
        bottle_py[10*i +: 10] = 10'(v);
    endtask

    // overlap, wrap to (0,0), frame_tick cycle; collision visible afterwards
    task automatic frame_catch(input logic [3:0] mask);
        pix(100, 300, 1'b1, mask);
        pix(5, 5, 1'b0, 4'b0);
        pix(0, 0, 1'b0, 4'b0);
        pix(0, 1, 1'b0, 4'b0);
    endtask

    task automatic respawn(input logic [3:0] mask);
        pix(7, 7, 1'b0, mask);
    endtask

    initial begin
        reset = 1'b0; x = 10'd0; y = 10'd0; player_print = 1'b0; bottle_print = 4'b0;
        bottle_py = '0; start = 1'b0; pause_btn = 1'b0;
        for (int i = 0; i < 4; i++) set_py(i, 100);
        tick(); tick();
        reset = 1'b1;
        tick();
        chk("rst_pause", pause, 1);
        chk("rst_lives", lives, 3);
        chk("rst_score", score, 0);
        chk("rst_collision", collision, 0);
        chk("rst_game_over", game_over, 0);

        start = 1'b1; tick(); start = 1'b0;
        chk("start_pause", pause, 0);

        frame_catch(4'b0010);
        exp_score++;
        chk("catch1_collision", collision, 4'b0010);
        chk("catch1_score", score, exp_score);
        respawn(4'b0010);
        chk("catch1_clear", collision, 0);

        for (int k = 0; k < 8; k++) begin
            frame_catch(4'b0001);
            respawn(4'b0001);
            exp_score++;
        end
        chk("score9", score, 9);
        chk("level0", level, 0);

        frame_catch(4'b1001);
        exp_score += 2;
        chk("dual_collision", collision, 4'b1001);
        chk("dual_score", score, 11);
        chk("dual_level", level, 1);
        respawn(4'b1001);

        start = 1'b1; pix(5, 5, 1'b0, 4'b0); start = 1'b0;
        chk("start_in_play", score, 11);

        set_py(2, 400); pix(5, 5, 1'b0, 4'b0);
        set_py(2, 450); pix(5, 5, 1'b0, 4'b0);
        set_py(2, 459); pix(5, 5, 1'b0, 4'b0);
        chk("miss_459", lives, 3);
        set_py(2, 460); pix(5, 5, 1'b0, 4'b0);
        chk("miss_460", lives, 2);
        set_py(2, 470);
        for (int k = 0; k < 1000; k++) pix(5, 5, 1'b0, 4'b0);
        chk("miss_hold", lives, 2);

        pix(100, 300, 1'b1, 4'b0001);
        set_py(0, 470); pix(5, 5, 1'b0, 4'b0);
        chk("catch_wins_pend", lives, 2);
        pix(0, 0, 1'b0, 4'b0);
        pix(0, 1, 1'b0, 4'b0);
        exp_score++;
        chk("catch_wins_collision", collision, 4'b0001);
        pix(5, 5, 1'b0, 4'b0);
        set_py(0, 100); respawn(4'b0001);
        chk("catch_wins_lives", lives, 2);
        chk("catch_wins_score", score, exp_score);

        set_py(3, 470); pix(5, 5, 1'b0, 4'b0);
        chk("miss_single", lives, 1);
        set_py(0, 470); set_py(1, 470); pix(5, 5, 1'b0, 4'b0);
        chk("miss_double_sat", lives, 0);
        chk("zero_still_play", game_over, 0);
        pix(5, 5, 1'b0, 4'b0);
        chk("over_game_over", game_over, 1);
        chk("over_pause", pause, 1);

        for (int i = 0; i < 4; i++) set_py(i, 100);
        start = 1'b1; pix(5, 5, 1'b0, 4'b0); start = 1'b0;
        chk("restart_pause", pause, 0);
        chk("restart_lives", lives, 3);
        chk("restart_score", score, 0);
        chk("restart_level", level, 0);

        frame_catch(4'b0001);
        respawn(4'b0001);
        chk("restart_catch", score, 1);

        pause_btn = 1'b1; pix(50, 50, 1'b0, 4'b0);
        chk("paused", pause, 1);
        frame_catch(4'b0100);
        chk("paused_collision", collision, 0);
        chk("paused_score", score, 1);
        pause_btn = 1'b0; pix(5, 5, 1'b0, 4'b0);
        pause_btn = 1'b1; pix(5, 5, 1'b0, 4'b0);
        chk("resumed", pause, 0);
        pix(0, 0, 1'b0, 4'b0); pix(0, 1, 1'b0, 4'b0); pix(3, 3, 1'b0, 4'b0);
        chk("resumed_collision", collision, 0);
        chk("resumed_score", score, 1);

        frame_catch(4'b1000);
        chk("pre_reset_collision", collision, 4'b1000);
        chk("pre_reset_score", score, 2);
        reset = 1'b0; pix(5, 5, 1'b0, 4'b0); reset = 1'b1;
        chk("midrst_collision", collision, 0);
        chk("midrst_score", score, 0);
        chk("midrst_pause", pause, 1);
        chk("midrst_lives", lives, 3);
        chk("midrst_level", level, 0);
        pix(5, 5, 1'b0, 4'b0);
        chk("midrst_idle", pause, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
